// File: rtl/vrf_arb_pkg.sv
// rtl/vrf_arb_pkg.sv - shared types and width helpers for the VRF port arbiter
// Contents:
//   arb_state_e : arbiter state (free round-robin or locked to one owner)
//   addr_w()    : RAM address width for a given depth
//   idx_w()     : requester index width for a given requester count
package vrf_arb_pkg;

   typedef enum logic {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_e;

   function automatic int addr_w(input int depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction

   function automatic int idx_w(input int num_req);
      return (num_req < 2) ? 1 : $clog2(num_req);
   endfunction

endpackage

// File: rtl/vrf_rr_picker.sv
// rtl/vrf_rr_picker.sv - combinational find-first-set starting at a rotating pointer
// Ports:
//   req : request vector
//   ptr : index searched first; the search wraps modulo NumReq
//   gnt : one-hot winner (all zero when no request)
//   idx : binary index of the winner (0 when no request)
module vrf_rr_picker #(
   parameter int NumReq = 3,
   parameter int IdxW   = 2
) (
   input  logic [NumReq-1:0] req,
   input  logic [IdxW-1:0]   ptr,
   output logic [NumReq-1:0] gnt,
   output logic [IdxW-1:0]   idx
);

   always_comb begin
      int            j;
      logic [IdxW-1:0] jj;
      logic          found;
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      j     = 0;
      jj    = '0;
      for (int k = 0; k < NumReq; k++) begin
         j = int'(ptr) + k;
         if (j >= NumReq) j = j - NumReq;
         jj = IdxW'(j);
         if (!found && req[jj]) begin
            found   = 1'b1;
            gnt[jj] = 1'b1;
            idx     = jj;
         end
      end
   end

endmodule

// File: rtl/vrf_port_arbiter.sv
// rtl/vrf_port_arbiter.sv - lockable round-robin arbiter sharing one VRF RAM port
// Ports:
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   req_i, we_i, lock_i    : per-requester request, write enable, keep-ownership
//   addr_i, wdata_i        : packed per-requester address / write data (slice i = requester i)
//   gnt_o                  : one-hot grant, combinational, access happens this cycle
//   rvalid_o, rdata_o      : per-requester read valid (cycle after grant), shared read data
//   ram_req_o .. ram_wdata_o : RAM access driven from the granted slice
//   ram_rdata_i            : RAM registered read data
module vrf_port_arbiter
   import vrf_arb_pkg::*;
#(
   parameter int  NumReq  = 3,
   parameter int  Width   = 128,
   parameter int  Depth   = 256,
   parameter int  MaxLock = 8,
   localparam int AddrW   = addr_w(Depth),
   localparam int IdxW    = idx_w(NumReq),
   localparam int CntW    = $clog2(MaxLock + 1)
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [NumReq-1:0]       req_i,
   input  logic [NumReq-1:0]       we_i,
   input  logic [NumReq-1:0]       lock_i,
   input  logic [NumReq*AddrW-1:0] addr_i,
   input  logic [NumReq*Width-1:0] wdata_i,
   output logic [NumReq-1:0]       gnt_o,
   output logic [NumReq-1:0]       rvalid_o,
   output logic [Width-1:0]        rdata_o,
   output logic                    ram_req_o,
   output logic                    ram_we_o,
   output logic [AddrW-1:0]        ram_addr_o,
   output logic [Width-1:0]        ram_wdata_o,
   input  logic [Width-1:0]        ram_rdata_i
);

   arb_state_e        state;
   logic [IdxW-1:0]   owner;
   logic [IdxW-1:0]   rr_ptr;
   logic [CntW-1:0]   lock_cnt;
   logic [NumReq-1:0] pick_gnt;
   logic [IdxW-1:0]   pick_idx;
   logic [IdxW-1:0]   sel_idx;
   logic [IdxW-1:0]   next_ptr;
   logic              hold;

   vrf_rr_picker #(
      .NumReq (NumReq),
      .IdxW   (IdxW)
   ) u_picker (
      .req (req_i),
      .ptr (rr_ptr),
      .gnt (pick_gnt),
      .idx (pick_idx)
   );

   // The lock stays in force while the owner still requests or still holds
   // lock. Owner dropping both releases immediately, so round-robin arbitration
   // runs in the same cycle and no slot is lost.
   always_comb begin
      hold    = (state == ARB_LOCKED) && (req_i[owner] || lock_i[owner]);
      gnt_o   = '0;
      sel_idx = pick_idx;
      if (hold) begin
         sel_idx      = owner;
         gnt_o[owner] = req_i[owner];
      end else begin
         gnt_o = pick_gnt;
      end
   end

   assign next_ptr    = (int'(sel_idx) == NumReq - 1) ? '0 : sel_idx + 1'b1;
   assign ram_req_o   = |gnt_o;
   assign ram_we_o    = we_i[sel_idx];
   assign ram_addr_o  = addr_i[int'(sel_idx)*AddrW +: AddrW];
   assign ram_wdata_o = wdata_i[int'(sel_idx)*Width +: Width];
   assign rdata_o     = ram_rdata_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state    <= ARB_IDLE;
         owner    <= '0;
         rr_ptr   <= '0;
         lock_cnt <= '0;
         rvalid_o <= '0;
      end else begin
         rvalid_o <= (ram_req_o && !ram_we_o) ? gnt_o : '0;
         if (ram_req_o) begin
            if (hold) begin
               // rr_ptr already equals owner+1 from the locking grant; it is
               // rewritten only on exit so the value is explicit there.
               if (lock_i[owner] && (int'(lock_cnt) + 1 < MaxLock)) begin
                  lock_cnt <= lock_cnt + 1'b1;
               end else begin
                  state    <= ARB_IDLE;
                  lock_cnt <= '0;
                  rr_ptr   <= next_ptr;
               end
            end else begin
               rr_ptr <= next_ptr;
               // With MaxLock of 1 the first grant already exhausts the budget.
               if (lock_i[pick_idx] && MaxLock > 1) begin
                  state    <= ARB_LOCKED;
                  owner    <= pick_idx;
                  lock_cnt <= CntW'(1);
               end else begin
                  state    <= ARB_IDLE;
                  lock_cnt <= '0;
               end
            end
         end else if (!hold) begin
            state    <= ARB_IDLE;
            lock_cnt <= '0;
         end
      end
   end

   gnt_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(gnt_o));
   rvalid_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(rvalid_o));
   gnt_needs_req: assert property (@(posedge clk_i) disable iff (!rst_ni) (gnt_o & ~req_i) == '0);

endmodule

// File: tb/tb_vrf_port_arbiter.sv
// tb/tb_vrf_port_arbiter.sv - scoreboard bench for the VRF port arbiter
module tb_vrf_port_arbiter;
   localparam int N  = 3;
   localparam int W  = 128;
   localparam int D  = 256;
   localparam int ML = 8;
   localparam int AW = 8;

   logic           clk = 1'b0;
   logic           rst_ni;
   logic [N-1:0]   req, we, lock;
   logic [N*AW-1:0] addr;
   logic [N*W-1:0] wdata;
   logic [N-1:0]   gnt, rvalid;
   logic [W-1:0]   rdata;
   logic           ram_req, ram_we;
   logic [AW-1:0]  ram_addr;
   logic [W-1:0]   ram_wdata, ram_rdata;

   always #5 clk = ~clk;

   vrf_port_arbiter #(.NumReq(N), .Width(W), .Depth(D), .MaxLock(ML)) dut (
      .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .we_i(we), .lock_i(lock),
      .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
      .ram_req_o(ram_req), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
      .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
   );

   // RAM macro: 1-cycle read latency, read data unchanged on write cycles
   logic [W-1:0] ram [D];
   always @(posedge clk) begin
      if (ram_req) begin
         if (ram_we) ram[ram_addr] <= ram_wdata;
         else        ram_rdata     <= ram[ram_addr];
      end
   end

   // Reference model state
   logic [W-1:0] ref_mem [D];
   bit           m_locked;
   int           m_owner, m_ptr, m_cnt;

   typedef struct { int idx; logic [W-1:0] data; int cyc; } rd_t;
   rd_t sb[$];

   int n_cmp = 0, n_bad = 0, cyc = 0;
   int           a_addr [N];
   logic [W-1:0] a_data [N];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [W-1:0] word(input int i);
      logic [7:0] b;
      b = 8'((i + 1) * 17);
      return {16{b}};
   endfunction

   function automatic void chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endfunction

   function automatic int model_winner(input logic [N-1:0] r, input logic [N-1:0] l);
      if (m_locked && (r[m_owner] || l[m_owner])) return r[m_owner] ? m_owner : -1;
      for (int k = 0; k < N; k++) if (r[(m_ptr + k) % N]) return (m_ptr + k) % N;
      return -1;
   endfunction

   function automatic void model_update(input int win, input logic [N-1:0] r, input logic [N-1:0] l);
      bit held;
      held = m_locked && (r[m_owner] || l[m_owner]);
      if (win < 0) begin
         if (!held) m_locked = 0;
      end else if (held) begin
         m_cnt++;
         if (!l[win] || m_cnt >= ML) begin
            m_locked = 0;
            m_ptr    = (win + 1) % N;
         end
      end else begin
         m_ptr = (win + 1) % N;
         if (l[win] && ML > 1) begin
            m_locked = 1; m_owner = win; m_cnt = 1;
         end else begin
            m_locked = 0;
         end
      end
   endfunction

   function automatic void model_reset();
      m_locked = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;
      sb.delete();
   endfunction

   // One clock cycle: drive, check the combinational grant/mux, queue read expectations
   task automatic cycle(input logic [N-1:0] r, input logic [N-1:0] w, input logic [N-1:0] l,
                        output logic [N-1:0] g);
      int win;
      logic [N-1:0] eg;
      #1;
      req = r; we = w; lock = l;
      for (int i = 0; i < N; i++) begin
         addr[i*AW +: AW] = AW'(a_addr[i]);
         wdata[i*W +: W]  = a_data[i];
      end
      #2;
      win = model_winner(r, l);
      eg = '0;
      if (win >= 0) eg[win] = 1'b1;
      g = gnt;
      chk("gnt", gnt, eg);
      chk("ram_req", ram_req, (win >= 0));
      if (win >= 0) begin
         chk("ram_we", ram_we, w[win]);
         chk("ram_addr", ram_addr, a_addr[win]);
         if (w[win]) begin
            chk("ram_wdata", ram_wdata, a_data[win]);
            ref_mem[a_addr[win]] = a_data[win];
         end else begin
            sb.push_back('{win, ref_mem[a_addr[win]], cyc + 1});
         end
      end
      model_update(win, r, l);
      @(posedge clk);
   endtask

   task automatic do_reset();
      req = '0; we = '0; lock = '0;
      rst_ni = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_rvalid", rvalid, '0);
      chk("reset_gnt", gnt, '0);
      chk("reset_ram_req", ram_req, 1'b0);
      @(negedge clk) rst_ni = 1'b1;
      @(posedge clk);
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents read data
   always @(posedge clk) begin
      rd_t e;
      logic [N-1:0] ev;
      #2;
      if (rst_ni === 1'b1) begin
         if (rvalid !== '0) begin
            if (sb.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL rvalid_unexpected: got %b expected 000", rvalid);
            end else begin
               e = sb.pop_front();
               ev = '0; ev[e.idx] = 1'b1;
               chk("rvalid", rvalid, ev);
               chk("rvalid_cycle", cyc, e.cyc);
               chk("rdata", rdata, e.data);
            end
         end else begin
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
               e = sb.pop_front();
               n_cmp++; n_bad++;
               $display("FAIL rvalid_missing: got 000 expected requester %0d", e.idx);
            end
         end
      end
   end

   initial begin
      logic [N-1:0] g;
      logic [N-1:0] gl [12];
      bit           pend [N];
      bit           pwe  [N];
      int           waitc [N];
      logic [N-1:0] r, w, l;
      int           run;

      for (int i = 0; i < D; i++) begin
         ram[i] = word(i); ref_mem[i] = word(i);
      end
      for (int i = 0; i < N; i++) begin
         a_addr[i] = i; a_data[i] = '0; pend[i] = 0; pwe[i] = 0; waitc[i] = 0;
      end
      req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
      do_reset();

      // Round-robin order from reset with all three reading
      cycle(3'b111, 3'b000, 3'b000, g); chk("rr_first", g, 3'b001);
      cycle(3'b111, 3'b000, 3'b000, g); chk("rr_second", g, 3'b010);
      cycle(3'b111, 3'b000, 3'b000, g); chk("rr_third", g, 3'b100);

      // Write then read of the same address on the next cycle
      a_addr[2] = 5; a_data[2] = {16{8'hA5}};
      cycle(3'b100, 3'b100, 3'b000, g); chk("raw_write_gnt", g, 3'b100);
      a_addr[0] = 5;
      cycle(3'b001, 3'b000, 3'b000, g);
      #1;
      chk("raw_rvalid", rvalid, 3'b001);
      chk("raw_rdata", rdata, {16{8'hA5}});

      // Lock held past MaxLock: forced release then round-robin resumes
      do_reset();
      cycle(3'b010, 3'b000, 3'b010, gl[0]);
      for (int t = 1; t < 12; t++) cycle(3'b111, 3'b000, 3'b010, gl[t]);
      run = 0;
      while (run < 12 && gl[run] == 3'b010) run++;
      chk("lock_run_len", run, ML);
      chk("after_release_0", gl[8], 3'b100);
      chk("after_release_1", gl[9], 3'b001);
      cycle(3'b000, 3'b000, 3'b000, g);

      // Locked owner bubbles, then releases with no lost cycle
      do_reset();
      cycle(3'b001, 3'b000, 3'b001, g); chk("lock_take", g, 3'b001);
      cycle(3'b010, 3'b000, 3'b001, g); chk("bubble_0", g, 3'b000);
      cycle(3'b010, 3'b000, 3'b001, g); chk("bubble_1", g, 3'b000);
      cycle(3'b010, 3'b000, 3'b000, g); chk("release_same_cycle", g, 3'b010);
      cycle(3'b000, 3'b000, 3'b000, g);

      // Reset in the cycle after a read grant
      do_reset();
      a_addr[1] = 3;
      cycle(3'b010, 3'b000, 3'b000, g); chk("pre_reset_gnt", g, 3'b010);
      #1 req = '0;
      #2;
      chk("pre_reset_rvalid", rvalid, 3'b010);
      rst_ni = 1'b0;
      model_reset();
      #1;
      chk("mid_reset_rvalid", rvalid, 3'b000);
      @(negedge clk) rst_ni = 1'b1;
      @(posedge clk);
      cycle(3'b111, 3'b000, 3'b000, g); chk("post_reset_ptr", g, 3'b001);
      cycle(3'b000, 3'b000, 3'b000, g);

      // Randomised traffic with handshake-holding requesters
      do_reset();
      for (int t = 0; t < 10000; t++) begin
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(0, 2) != 0) begin
               pend[i]   = 1;
               pwe[i]    = 1'($urandom_range(0, 1));
               a_addr[i] = $urandom_range(0, 7);
               a_data[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
               waitc[i]  = 0;
            end
            r[i] = pend[i];
            w[i] = pwe[i];
            l[i] = pend[i] && ($urandom_range(0, 3) != 0);
         end
         cycle(r, w, l, g);
         for (int i = 0; i < N; i++) begin
            if (pend[i]) begin
               if (g[i]) begin
                  n_cmp++;
                  if (waitc[i] > N * ML) begin
                     n_bad++;
                     $display("FAIL grant_latency: got %0d cycles expected at most %0d", waitc[i], N * ML);
                  end
                  pend[i] = 0;
               end else begin
                  waitc[i]++;
               end
            end
         end
      end
      cycle(3'b000, 3'b000, 3'b000, g);
      cycle(3'b000, 3'b000, 3'b000, g);
      #3;
      chk("scoreboard_drained", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
